// File: rtl/enemy_scheduler.sv
// enemy_scheduler: lifecycle controller for a bank of turtle enemies.
// Spawns each slot as the camera approaches, turns collision events into
// the turtles' toggle-style impulse inputs, sequences shell recovery and
// kicks, drives each turtle's reset line and emits score events.
//
// Handshake: collide_valid is a one-cycle qualifier for collide_slot and
// collide_stomp; there is no ready, so every valid event is consumed in the
// cycle it is presented (or ignored if the target slot cannot react).
module enemy_scheduler #(
   parameter int                       NUM_SLOTS    = 4,
   parameter logic [11*NUM_SLOTS-1:0]  SPAWN_X      = {11'd600, 11'd400, 11'd200, 11'd100},
   parameter int                       SPAWN_DIST   = 320,
   parameter int                       SHELL_FRAMES = 180,
   localparam int                      SW           = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   frame_tick,
   input  logic [10:0]            cam_x,
   input  logic                   collide_valid,
   input  logic [SW-1:0]          collide_slot,
   input  logic                   collide_stomp,
   input  logic [NUM_SLOTS-1:0]   offscreen,
   output logic [NUM_SLOTS-1:0]   initial_show,
   output logic [NUM_SLOTS-1:0]   collapsion_impulse,
   output logic [NUM_SLOTS-1:0]   press_impulse,
   output logic [NUM_SLOTS-1:0]   turtle_rst,
   output logic                   score_pulse,
   output logic [SW-1:0]          score_slot,
   output logic [3*NUM_SLOTS-1:0] slot_state
);

   typedef enum logic [2:0] {
      S_EMPTY  = 3'd0,
      S_WALK   = 3'd1,
      S_SHELL  = 3'd2,
      S_KICKED = 3'd3,
      S_DEAD   = 3'd4
   } state_t;

   localparam logic [11:0] DIST12   = 12'(SPAWN_DIST);
   localparam logic [7:0]  SHELL_LAST = 8'(SHELL_FRAMES - 1);

   state_t               st      [NUM_SLOTS];
   logic [7:0]           timer   [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] spawned;
   logic [NUM_SLOTS-1:0] spawn_ok;
   logic [NUM_SLOTS-1:0] hit;

   // Per-slot spawn test (12-bit so cam_x + distance cannot wrap) and collide decode.
   // Out-of-range slot numbers simply never match any slot.
   always_comb begin
      spawn_ok = '0;
      hit      = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         spawn_ok[i] = ({1'b0, cam_x} + DIST12) >= {1'b0, SPAWN_X[11*i +: 11]};
         hit[i]      = collide_valid && (int'(collide_slot) == i);
      end
   end

   // Debug view of every slot's state code.
   always_comb begin
      slot_state = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         slot_state[3*i +: 3] = st[i];
      end
   end

   // Per-slot lifecycle FSMs with registered outputs; offscreen beats collide.
   always_ff @(posedge clk) begin
      if (rstn) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            st[i]    <= S_EMPTY;
            timer[i] <= 8'd0;
         end
         spawned            <= '0;
         initial_show       <= '0;
         collapsion_impulse <= '0;
         press_impulse      <= '0;
         turtle_rst         <= '1;
         score_pulse        <= 1'b0;
         score_slot         <= '0;
      end else begin
         score_pulse <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            case (st[i])
               S_EMPTY: begin
                  if (spawn_ok[i] && !spawned[i]) begin
                     st[i]           <= S_WALK;
                     spawned[i]      <= 1'b1;
                     turtle_rst[i]   <= 1'b0;
                     initial_show[i] <= 1'b1;
                  end else begin
                     turtle_rst[i]   <= 1'b1;
                     initial_show[i] <= 1'b0;
                  end
               end
               S_WALK: begin
                  turtle_rst[i] <= 1'b0;
                  if (offscreen[i]) begin
                     st[i]           <= S_DEAD;
                     initial_show[i] <= 1'b0;
                  end else if (hit[i] && collide_stomp) begin
                     press_impulse[i] <= ~press_impulse[i];
                     timer[i]         <= 8'd0;
                     st[i]            <= S_SHELL;
                     score_pulse      <= 1'b1;
                     score_slot       <= SW'(i);
                  end else if (hit[i]) begin
                     collapsion_impulse[i] <= ~collapsion_impulse[i];
                  end
               end
               S_SHELL: begin
                  turtle_rst[i] <= 1'b0;
                  if (offscreen[i]) begin
                     st[i]           <= S_DEAD;
                     initial_show[i] <= 1'b0;
                  end else if (hit[i]) begin
                     press_impulse[i] <= ~press_impulse[i];
                     st[i]            <= S_KICKED;
                     score_pulse      <= 1'b1;
                     score_slot       <= SW'(i);
                  end else if (frame_tick && (timer[i] == SHELL_LAST)) begin
                     // Recovery: pulse the turtle's reset so it comes back walking.
                     st[i]         <= S_WALK;
                     timer[i]      <= 8'd0;
                     turtle_rst[i] <= 1'b1;
                  end else if (frame_tick) begin
                     timer[i] <= timer[i] + 8'd1;
                  end
               end
               S_KICKED: begin
                  turtle_rst[i] <= 1'b0;
                  if (offscreen[i]) begin
                     st[i]           <= S_DEAD;
                     initial_show[i] <= 1'b0;
                  end else if (hit[i] && collide_stomp) begin
                     press_impulse[i] <= ~press_impulse[i];
                     timer[i]         <= 8'd0;
                     st[i]            <= S_SHELL;
                  end else if (hit[i]) begin
                     collapsion_impulse[i] <= ~collapsion_impulse[i];
                  end
               end
               default: begin
                  // DEAD: hidden, released from reset, impulses frozen until rstn.
                  st[i]           <= S_DEAD;
                  turtle_rst[i]   <= 1'b0;
                  initial_show[i] <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_enemy_scheduler.sv
// tb_enemy_scheduler: directed bench for enemy_scheduler.
// Spawn positions are overridden so slot0=100, slot1=600, slot2=900, slot3=1000:
// cam_x=0 spawns only slot0, cam_x=281 (601) adds slot1, cam_x=2047 adds 2 and 3.
module tb_enemy_scheduler;

   logic        clk = 1'b0;
   logic        rstn;
   logic        frame_tick;
   logic [10:0] cam_x;
   logic        collide_valid;
   logic [1:0]  collide_slot;
   logic        collide_stomp;
   logic [3:0]  offscreen;
   logic [3:0]  initial_show;
   logic [3:0]  collapsion_impulse;
   logic [3:0]  press_impulse;
   logic [3:0]  turtle_rst;
   logic        score_pulse;
   logic [1:0]  score_slot;
   logic [11:0] slot_state;

   int checks   = 0;
   int failures = 0;

   enemy_scheduler #(
      .NUM_SLOTS    (4),
      .SPAWN_X      ({11'd1000, 11'd900, 11'd600, 11'd100}),
      .SPAWN_DIST   (320),
      .SHELL_FRAMES (180)
   ) dut (
      .clk                (clk),
      .rstn               (rstn),
      .frame_tick         (frame_tick),
      .cam_x              (cam_x),
      .collide_valid      (collide_valid),
      .collide_slot       (collide_slot),
      .collide_stomp      (collide_stomp),
      .offscreen          (offscreen),
      .initial_show       (initial_show),
      .collapsion_impulse (collapsion_impulse),
      .press_impulse      (press_impulse),
      .turtle_rst         (turtle_rst),
      .score_pulse        (score_pulse),
      .score_slot         (score_slot),
      .slot_state         (slot_state)
   );

   // Clock
   always #5 clk = ~clk;

   // Advance one edge; inputs and samples both sit 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic collide(input logic [1:0] slot, input logic stomp);
      collide_valid = 1'b1;
      collide_slot  = slot;
      collide_stomp = stomp;
      step();
      collide_valid = 1'b0;
      collide_stomp = 1'b0;
   endtask

   initial begin
      rstn = 1'b1; frame_tick = 1'b0; cam_x = 11'd0;
      collide_valid = 1'b0; collide_slot = 2'd0; collide_stomp = 1'b0; offscreen = 4'd0;
      step(); step();

      // Reset state
      chk("rst_state", 32'(slot_state), 32'h000);
      chk("rst_trst",  32'(turtle_rst), 32'hF);
      chk("rst_show",  32'(initial_show), 32'h0);
      chk("rst_press", 32'(press_impulse), 32'h0);
      chk("rst_coll",  32'(collapsion_impulse), 32'h0);
      chk("rst_score", 32'(score_pulse), 32'h0);

      // Spawn slot0 only at cam_x=0
      rstn = 1'b0;
      step();
      chk("spawn0_state", 32'(slot_state), 32'h001);
      chk("spawn0_show",  32'(initial_show), 32'h1);
      chk("spawn0_trst",  32'(turtle_rst), 32'hE);
      step();
      chk("spawn0_hold", 32'(slot_state), 32'h001);

      // cam_x=281 spawns slot1
      cam_x = 11'd281;
      step();
      chk("spawn1_show",  32'(initial_show), 32'h3);
      chk("spawn1_trst",  32'(turtle_rst), 32'hC);
      chk("spawn1_state", 32'(slot_state), 32'h009);

      // Side hit on walking slot0
      collide(2'd0, 1'b0);
      chk("side_coll",  32'(collapsion_impulse), 32'h1);
      chk("side_state", 32'(slot_state), 32'h009);
      chk("side_score", 32'(score_pulse), 32'h0);

      // Stomp slot0 into shell
      collide(2'd0, 1'b1);
      chk("stomp_press", 32'(press_impulse), 32'h1);
      chk("stomp_state", 32'(slot_state), 32'h00A);
      chk("stomp_score", 32'(score_pulse), 32'h1);
      chk("stomp_sslot", 32'(score_slot), 32'h0);
      step();
      chk("stomp_score_1cyc", 32'(score_pulse), 32'h0);

      // Shell recovery after 180 frame ticks
      frame_tick = 1'b1;
      for (int k = 0; k < 179; k++) step();
      chk("shell_179", 32'(slot_state), 32'h00A);
      chk("shell_179_trst", 32'(turtle_rst), 32'hC);
      step();
      chk("recover_state", 32'(slot_state), 32'h009);
      chk("recover_trst",  32'(turtle_rst), 32'hD);
      chk("recover_press", 32'(press_impulse), 32'h1);
      frame_tick = 1'b0;
      step();
      chk("recover_trst_1cyc", 32'(turtle_rst), 32'hC);

      // Kick sequence on slot1
      collide(2'd1, 1'b1);
      chk("k_stomp_state", 32'(slot_state), 32'h011);
      chk("k_stomp_press", 32'(press_impulse), 32'h3);
      chk("k_stomp_sslot", 32'(score_slot), 32'h1);
      collide(2'd1, 1'b0);
      chk("kick_state", 32'(slot_state), 32'h019);
      chk("kick_press", 32'(press_impulse), 32'h1);
      chk("kick_score", 32'(score_pulse), 32'h1);
      chk("kick_sslot", 32'(score_slot), 32'h1);
      collide(2'd1, 1'b0);
      chk("bounce_coll",  32'(collapsion_impulse), 32'h3);
      chk("bounce_state", 32'(slot_state), 32'h019);
      chk("bounce_score", 32'(score_pulse), 32'h0);
      collide(2'd1, 1'b1);
      chk("restomp_state", 32'(slot_state), 32'h011);
      chk("restomp_press", 32'(press_impulse), 32'h3);
      chk("restomp_score", 32'(score_pulse), 32'h0);

      // Offscreen beats a stomp on slot1
      offscreen = 4'b0010;
      collide(2'd1, 1'b1);
      offscreen = 4'b0000;
      chk("prio_state", 32'(slot_state), 32'h021);
      chk("prio_press", 32'(press_impulse), 32'h3);
      chk("prio_score", 32'(score_pulse), 32'h0);
      chk("prio_show",  32'(initial_show), 32'h1);
      chk("prio_trst",  32'(turtle_rst), 32'hC);
      collide(2'd1, 1'b0);
      chk("dead_ignore_state", 32'(slot_state), 32'h021);
      chk("dead_ignore_coll",  32'(collapsion_impulse), 32'h3);

      // Mid-shell reset on slot0 at timer=90
      collide(2'd0, 1'b1);
      chk("mid_stomp_press", 32'(press_impulse), 32'h2);
      frame_tick = 1'b1;
      for (int k = 0; k < 90; k++) step();
      frame_tick = 1'b0;
      chk("mid_shell_state", 32'(slot_state), 32'h022);
      rstn = 1'b1;
      step();
      rstn = 1'b0;
      chk("mid_rst_state", 32'(slot_state), 32'h000);
      chk("mid_rst_trst",  32'(turtle_rst), 32'hF);
      chk("mid_rst_press", 32'(press_impulse), 32'h0);
      chk("mid_rst_coll",  32'(collapsion_impulse), 32'h0);
      step();
      chk("respawn_state", 32'(slot_state), 32'h009);
      chk("respawn_show",  32'(initial_show), 32'h3);

      // Collide to an EMPTY slot is ignored
      collide(2'd2, 1'b1);
      chk("empty_ignore_state", 32'(slot_state), 32'h009);
      chk("empty_ignore_score", 32'(score_pulse), 32'h0);
      chk("empty_ignore_press", 32'(press_impulse), 32'h0);

      // Walking slot0 leaves the screen
      offscreen = 4'b0001;
      step();
      offscreen = 4'b0000;
      chk("walk_dead_state", 32'(slot_state), 32'h00C);
      chk("walk_dead_show",  32'(initial_show), 32'h2);

      // Far camera: slots 2 and 3 spawn together, dead slot0 is not re-armed
      cam_x = 11'd2047;
      step();
      chk("multi_state", 32'(slot_state), 32'h24C);
      chk("multi_show",  32'(initial_show), 32'hE);
      chk("multi_trst",  32'(turtle_rst), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/enemy_scheduler.md
Name: enemy_scheduler

Overview:
- Lifecycle controller for up to NUM_SLOTS turtle enemy instances.
- Decides when each turtle spawns as the camera scrolls, and routes per-slot collision/stomp events into each turtle's toggle-style impulse inputs.
- Sequences shell recovery and kick, owns each turtle's reset line, and emits score events.
- Sits between the collision detector / camera logic and the bank of turtle sprite instances.

Parameters:
- NUM_SLOTS, 4, number of turtle instances managed (slot index width 2 at default).
- SPAWN_X, {11'd600,11'd400,11'd200,11'd100}, packed 11*NUM_SLOTS world x spawn positions; slot i occupies bits [11i+10:11i].
- SPAWN_DIST, 320, a slot spawns when cam_x + SPAWN_DIST >= SPAWN_X[i], computed at 12 bits with no overflow.
- SHELL_FRAMES, 180, frame ticks a shelled turtle waits before recovering (8-bit timer).

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous, active-high reset; the name is kept per codebase convention.
- frame_tick  in  1  one-cycle pulse per video frame.
- cam_x  in  11  camera left-edge world x.
- collide_valid  in  1  one collision event this cycle.
- collide_slot  in  2  target slot of the event.
- collide_stomp  in  1  1 = player landed on top, 0 = side contact.
- offscreen  in  NUM_SLOTS  level, per slot; the turtle has left the playfield.
- initial_show  out  NUM_SLOTS  per-slot sprite visible.
- collapsion_impulse  out  NUM_SLOTS  per-slot toggle; each edge reverses the turtle's direction.
- press_impulse  out  NUM_SLOTS  per-slot toggle; each edge is a press (shell entry or kick).
- turtle_rst  out  NUM_SLOTS  per-slot active-high reset to the turtle instance.
- score_pulse  out  1  one-cycle pulse on a scoring stomp or kick.
- score_slot  out  2  slot that scored; valid when score_pulse = 1.
- slot_state  out  3*NUM_SLOTS  per-slot state code, for debug and verification.

Behaviour:
- Per slot, a registered FSM with codes EMPTY=0, WALK=1, SHELL=2, KICKED=3, DEAD=4. Slots are independent, and every slot updates in every cycle.
- Reset, applied while rstn=1 at the clock edge:
  - all slots go to EMPTY; spawned flags, timers, initial_show, both impulse vectors, score_pulse and score_slot clear to 0;
  - turtle_rst goes to all ones.
- EMPTY:
  - turtle_rst[i]=1 and initial_show[i]=0.
  - If the spawn condition holds, the slot moves to WALK on the next edge: turtle_rst[i]=0, initial_show[i]=1, spawned flag set.
  - A slot spawns once per reset; it is never re-armed.
- WALK:
  - A side collide toggles collapsion_impulse[i].
  - A stomp toggles press_impulse[i], clears the timer, moves the slot to SHELL, and pulses score (score_slot=i).
- SHELL:
  - Each frame_tick increments the timer.
  - When a frame_tick arrives with timer == SHELL_FRAMES-1, the slot goes to WALK and turtle_rst[i]=1 for exactly one cycle. No impulse toggles occur in that cycle.
  - Any collide (stomp or side) toggles press_impulse[i], moves the slot to KICKED, and pulses score.
- KICKED:
  - A side collide toggles collapsion_impulse[i] (the shell bounces).
  - A stomp toggles press_impulse[i], clears the timer, and moves the slot to SHELL. No score is given.
- DEAD:
  - initial_show[i]=0 and turtle_rst[i]=0; the impulses are frozen.
  - The slot stays DEAD until rstn.
- Any state except EMPTY and DEAD: offscreen[i]=1 moves the slot to DEAD on the next edge.
- Latency: every output change appears one clock after the causing input edge. All outputs are registered.
- Boundary rules:
  - A collide to a slot in EMPTY or DEAD is ignored.
  - collide_slot >= NUM_SLOTS is ignored.
  - offscreen has priority over a collide to the same slot in the same cycle: the slot goes to DEAD with no toggle and no score.
  - In SHELL, a collide and frame_tick in the same cycle: the collide wins, the slot goes to KICKED, and the timer is not incremented.
  - An impulse toggle never coincides with turtle_rst[i]=1 on the same slot.
  - Several slots may spawn in the same cycle.
  - At most one score_pulse per cycle, since at most one collide arrives per cycle.
  - rstn asserted mid-shell discards the timer; the slot returns to EMPTY and spawns again once the spawn condition holds after rstn deasserts.

Test Plan:
- Spawn:
  - Hold cam_x=0, release rstn → slot0 spawns (0+320 >= 100), slots 1/2 stay EMPTY.
  - Set cam_x=281 → slot1 spawns the next cycle: initial_show=4'b0011, turtle_rst=4'b1100.
- Side hit: WALK slot0, collide_valid=1, slot=0, stomp=0 → collapsion_impulse[0] toggles, state stays 1, no score_pulse.
- Stomp and recovery:
  - Stomp slot0 → press_impulse[0] toggles, slot_state[0]=2, score_pulse=1 with score_slot=0.
  - Then 180 frame_ticks → state 1 and turtle_rst[0]=1 for exactly one cycle.
- Kick:
  - SHELL slot1, side collide → press toggles, state=3, score.
  - A further side collide → collapsion toggles, state stays 3.
  - A stomp → state=2, no score.
- Priority: same cycle as a slot1 stomp, assert offscreen[1]=1 → state=4, no toggle, no score_pulse, initial_show[1]=0.
- Mid-operation reset: at timer=90 in SHELL, pulse rstn for one cycle → all slots EMPTY, turtle_rst=4'hF, impulses 0; the slot respawns next cycle given the cam_x condition.
